// File: rtl/reg_apb_slv.sv
// APB register slave. It provides zero-wait writes and two-cycle registered reads.
// It strobes NREG external registers and holds an internal sticky status / mask / irq block.
module reg_apb_slv #(
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 32,
  parameter int unsigned PAW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PAW-1:0]     paddr,
  input  logic [DW-1:0]      pwdata,
  output logic [DW-1:0]      prdata,
  output logic               pready,
  output logic               pslverr,
  output logic [NREG-1:0]    w_en,
  output logic [DW-1:0]      w_dat,
  input  logic [NREG*DW-1:0] r_dat,
  input  logic [DW-1:0]      sts_set,
  output logic               irq
);

  localparam int unsigned    IW      = PAW - 2;
  localparam logic [IW-1:0]  StsIdx  = IW'(NREG);
  localparam logic [IW-1:0]  MaskIdx = IW'(NREG + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdDone
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] prdata_q, prdata_d;
  logic [DW-1:0] sts_q, sts_d;
  logic [DW-1:0] mask_q, mask_d;
  logic          rd_err_q, rd_err_d;
  logic          irq_q;

  logic [IW-1:0] widx;
  logic          addr_err;
  logic          access;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] clr;

  assign widx     = paddr[PAW-1:2];
  assign addr_err = (paddr[1:0] != 2'b00) || (widx > MaskIdx);
  // Gated by rst_n so that no strobe or wait state leaks out while reset is held.
  assign access   = psel & penable & rst_n;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (widx == IW'(i)) begin
        rd_data = r_dat[i*DW +: DW];
      end
    end
    if (widx == StsIdx) begin
      rd_data = sts_q;
    end
    if (widx == MaskIdx) begin
      rd_data = mask_q;
    end
    if (addr_err) begin
      rd_data = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    prdata_d = prdata_q;
    rd_err_d = rd_err_q;
    mask_d   = mask_q;
    clr      = '0;
    w_en     = '0;
    pready   = 1'b1;
    pslverr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access && pwrite) begin
          pslverr = addr_err;
          if (!addr_err) begin
            for (int unsigned i = 0; i < NREG; i++) begin
              w_en[i] = (widx == IW'(i));
            end
            if (widx == StsIdx) begin
              clr = pwdata;
            end
            if (widx == MaskIdx) begin
              mask_d = pwdata;
            end
          end
        end else if (access && !pwrite) begin
          pready   = 1'b0;
          prdata_d = rd_data;
          rd_err_d = addr_err;
          state_d  = StRdWait;
        end
      end
      StRdWait: begin
        pslverr = rd_err_q;
        state_d = StRdDone;
      end
      StRdDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Set wins over a same-cycle W1C clear.
    sts_d = (sts_q & ~clr) | sts_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prdata_q <= '0;
      rd_err_q <= 1'b0;
      sts_q    <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
      rd_err_q <= rd_err_d;
      sts_q    <= sts_d;
      mask_q   <= mask_d;
      irq_q    <= |(sts_d & mask_q);
    end
  end

  assign prdata = prdata_q;
  assign w_dat  = pwdata;
  assign irq    = irq_q;

endmodule
